// File: rtl/fm_discriminator_decim.sv
// rtl/fm_discriminator_decim.sv - FM phase discriminator with integrate-and-dump decimation and 2-entry output FIFO
module fm_discriminator_decim #(
    parameter int IN_W  = 12,
    parameter int DECIM = 32,
    parameter int SHIFT = 3,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    en,
    input  logic signed [IN_W-1:0]  phase,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overflow,
    output logic                    clip
);
    localparam int CNT_W = $clog2(DECIM);
    localparam int ACC_W = IN_W + CNT_W;
    // Working width for the scaled sum: wide enough to hold both the sum and the output range
    localparam int CW    = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DECIM - 1);
    localparam logic signed [CW-1:0] OUT_MAX  = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [CW-1:0] OUT_MIN  = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W-1:0]  phase_in;
    logic                    en_in;
    logic signed [IN_W-1:0]  phase_prev;
    logic                    primed;
    logic signed [IN_W-1:0]  d;
    logic                    d_vld;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] sum_r;
    logic                    sum_vld;
    logic signed [CW-1:0]    r_wide;
    logic signed [OUT_W-1:0] res;
    logic                    sat;
    logic signed [OUT_W-1:0] tail;
    logic [1:0]              count;
    logic                    push;
    logic                    pop;

    // Capture the incoming sample and its enable so stage A works from registered inputs
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            phase_in <= '0;
            en_in    <= 1'b0;
        end else begin
            en_in <= en;
            if (en) begin
                phase_in <= phase;
            end
        end
    end

    // Stage A: first difference of phase; modular wrap falls out of IN_W-bit subtraction
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            phase_prev <= '0;
            primed     <= 1'b0;
            d          <= '0;
            d_vld      <= 1'b0;
        end else if (en_in) begin
            phase_prev <= phase_in;
            primed     <= 1'b1;
            if (primed) begin
                d     <= phase_in - phase_prev;
                d_vld <= 1'b1;
            end else begin
                d_vld <= 1'b0;
            end
        end else begin
            d_vld <= 1'b0;
        end
    end

    assign acc_next = acc + ACC_W'(d);

    // Stage B: integrate DECIM differences, then dump the sum and restart
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            acc     <= '0;
            cnt     <= '0;
            sum_r   <= '0;
            sum_vld <= 1'b0;
        end else if (d_vld) begin
            if (cnt == CNT_LAST) begin
                sum_r   <= acc_next;
                acc     <= '0;
                cnt     <= '0;
                sum_vld <= 1'b1;
            end else begin
                acc     <= acc_next;
                cnt     <= cnt + 1'b1;
                sum_vld <= 1'b0;
            end
        end else begin
            sum_vld <= 1'b0;
        end
    end

    assign r_wide = CW'(sum_r) >>> SHIFT;

    // Stage C: scale the dump sum and clamp to the signed output range
    always_comb begin
        res = r_wide[OUT_W-1:0];
        sat = 1'b0;
        if (r_wide > OUT_MAX) begin
            res = OUT_MAX[OUT_W-1:0];
            sat = 1'b1;
        end else if (r_wide < OUT_MIN) begin
            res = OUT_MIN[OUT_W-1:0];
            sat = 1'b1;
        end
    end

    assign push      = sum_vld;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid & out_ready;

    // Output FIFO: out_data is the registered head, tail holds the second entry
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            out_data <= '0;
            tail     <= '0;
            count    <= 2'd0;
            overflow <= 1'b0;
            clip     <= 1'b0;
        end else begin
            if (push && sat) begin
                clip <= 1'b1;
            end
            case (count)
                2'd0: begin
                    if (push) begin
                        out_data <= res;
                        count    <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        out_data <= res;
                    end else if (push) begin
                        tail  <= res;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        out_data <= tail;
                        if (push) begin
                            tail <= res;
                        end else begin
                            count <= 2'd1;
                        end
                    end else if (push) begin
                        overflow <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fm_discriminator_decim.sv
// tb/tb_fm_discriminator_decim.sv - self-checking bench for fm_discriminator_decim
module tb_fm_discriminator_decim;
    localparam int IN_W  = 12;
    localparam int DECIM = 32;
    localparam int OUT_W = 16;

    logic                    clk = 1'b0;
    logic                    areset;
    logic                    en;
    logic                    out_ready;
    logic signed [IN_W-1:0]  phase;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    overflow;
    logic                    clip;
    logic signed [OUT_W-1:0] s_data;
    logic                    s_valid;
    logic                    s_overflow;
    logic                    s_clip;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    int m_prev;
    int m_sum;
    int m_cnt;
    int edge_n = 0;
    bit m_primed;
    bit m_ovf;
    bit m_clip_a;
    bit m_clip_b;
    int pend_t[$];
    int pend_s[$];
    int q_a[$];
    int q_b[$];

    always #5 clk = ~clk;

    fm_discriminator_decim #(.IN_W(IN_W), .DECIM(DECIM), .SHIFT(3), .OUT_W(OUT_W)) dut (
        .clk(clk), .areset(areset), .en(en), .phase(phase),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .clip(clip)
    );

    fm_discriminator_decim #(.IN_W(IN_W), .DECIM(DECIM), .SHIFT(0), .OUT_W(OUT_W)) dut_sat (
        .clk(clk), .areset(areset), .en(en), .phase(phase),
        .out_data(s_data), .out_valid(s_valid), .out_ready(out_ready),
        .overflow(s_overflow), .clip(s_clip)
    );

    function automatic int wrap_diff(input int a, input int b);
        int d;
        d = (a - b) & ((1 << IN_W) - 1);
        if (d >= (1 << (IN_W - 1))) d -= (1 << IN_W);
        return d;
    endfunction

    // floor division by 2^sh, then clamp to the signed output range
    function automatic int scale(input int s, input int sh, output bit c);
        int div;
        int r;
        div = 1 << sh;
        r = (s >= 0) ? s / div : -((-s + div - 1) / div);
        c = 1'b0;
        if (r > (1 << (OUT_W - 1)) - 1) begin
            r = (1 << (OUT_W - 1)) - 1;
            c = 1'b1;
        end else if (r < -(1 << (OUT_W - 1))) begin
            r = -(1 << (OUT_W - 1));
            c = 1'b1;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_prev = 0; m_sum = 0; m_cnt = 0; m_primed = 0;
        m_ovf = 0; m_clip_a = 0; m_clip_b = 0;
        pend_t.delete(); pend_s.delete(); q_a.delete(); q_b.delete();
    endtask

    task automatic model_edge(input bit e, input int ph, input bit rdy);
        bit full;
        bit pop;
        bit ca;
        bit cb;
        int s;
        int ra;
        int rb;
        edge_n++;
        if (e) begin
            if (m_primed) begin
                m_sum += wrap_diff(ph, m_prev);
                m_cnt++;
                if (m_cnt == DECIM) begin
                    pend_t.push_back(edge_n + 3);
                    pend_s.push_back(m_sum);
                    m_sum = 0;
                    m_cnt = 0;
                end
            end
            m_primed = 1;
            m_prev = ph;
        end
        full = (q_a.size() == 2);
        pop  = (q_a.size() != 0) && rdy;
        if (pop) begin
            void'(q_a.pop_front());
            void'(q_b.pop_front());
        end
        if (pend_t.size() != 0 && pend_t[0] == edge_n) begin
            void'(pend_t.pop_front());
            s  = pend_s.pop_front();
            ra = scale(s, 3, ca);
            rb = scale(s, 0, cb);
            m_clip_a |= ca;
            m_clip_b |= cb;
            if (full && !pop) m_ovf = 1;
            else begin
                q_a.push_back(ra);
                q_b.push_back(rb);
            end
        end
    endtask

    task automatic step(input bit e, input int ph, input bit rdy);
        en = e;
        phase = IN_W'(ph);
        out_ready = rdy;
        @(posedge clk);
        model_edge(e, ph, rdy);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1; en = 1'b0; phase = '0; out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        areset = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1; en = 1'b0; phase = '0; out_ready = 1'b0;
        model_reset();
        #12;
        vectors += 4;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        if (out_data !== 16'sd0) begin miscompares++; $display("FAIL reset_data got %0d exp 0", out_data); end
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
        if (clip !== 1'b0) begin miscompares++; $display("FAIL reset_clip got %0b exp 0", clip); end
        @(posedge clk);
        #1;
        areset = 1'b0;
    endtask

    task automatic test_ramp();
        int ph = 0;
        int first = -1;
        int nres = 0;
        do_reset();
        for (int i = 1; i <= 134; i++) begin
            step(1'b1, ph, 1'b1);
            ph += 5;
            vectors++;
            if (out_valid !== (q_a.size() != 0)) begin miscompares++; $display("FAIL ramp_valid edge %0d got %0b exp %0b", i, out_valid, q_a.size() != 0); end
            if (out_valid === 1'b1) begin
                nres++;
                if (first < 0) first = i;
                vectors++;
                if (out_data !== 16'sd20) begin miscompares++; $display("FAIL ramp_data edge %0d got %0d exp 20", i, out_data); end
            end
        end
        vectors += 4;
        if (first != 36) begin miscompares++; $display("FAIL ramp_first_valid got edge %0d exp 36", first); end
        if (nres != 4) begin miscompares++; $display("FAIL ramp_count got %0d exp 4", nres); end
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL ramp_overflow got %0b exp 0", overflow); end
        if (clip !== 1'b0) begin miscompares++; $display("FAIL ramp_clip got %0b exp 0", clip); end
    endtask

    task automatic test_wrap();
        int ph = 447;
        int nres = 0;
        do_reset();
        for (int i = 1; i <= 70; i++) begin
            step(1'b1, ph, 1'b1);
            ph += 100;
            if (out_valid === 1'b1) begin
                nres++;
                vectors++;
                if (out_data !== 16'sd400) begin miscompares++; $display("FAIL wrap_data edge %0d got %0d exp 400", i, out_data); end
            end
        end
        vectors++;
        if (nres != 2) begin miscompares++; $display("FAIL wrap_count got %0d exp 2", nres); end
    endtask

    task automatic test_neg_gaps();
        int ph = 0;
        int last = -1;
        int nres = 0;
        bit e;
        do_reset();
        for (int i = 1; i <= 140; i++) begin
            e = (i % 2) == 1;
            step(e, ph, 1'b1);
            if (e) ph -= 7;
            if (out_valid === 1'b1) begin
                nres++;
                vectors++;
                if (out_data !== -16'sd28) begin miscompares++; $display("FAIL gaps_data edge %0d got %0d exp -28", i, out_data); end
                vectors++;
                if (last < 0 && i != 68) begin miscompares++; $display("FAIL gaps_first edge got %0d exp 68", i); end
                if (last >= 0 && i - last != 64) begin miscompares++; $display("FAIL gaps_interval got %0d exp 64", i - last); end
                last = i;
            end
        end
        vectors++;
        if (nres != 2) begin miscompares++; $display("FAIL gaps_count got %0d exp 2", nres); end
    endtask

    task automatic test_saturation();
        int nres = 0;
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            step(1'b1, (i % 2 == 1) ? 0 : -2048, 1'b1);
            if (s_valid === 1'b1) begin
                nres++;
                vectors += 2;
                if (s_data !== -16'sd32768) begin miscompares++; $display("FAIL sat_data got %0d exp -32768", s_data); end
                if (out_data !== -16'sd8192) begin miscompares++; $display("FAIL sat_shift3_data got %0d exp -8192", out_data); end
            end
        end
        vectors += 3;
        if (nres != 1) begin miscompares++; $display("FAIL sat_count got %0d exp 1", nres); end
        if (s_clip !== 1'b1) begin miscompares++; $display("FAIL sat_clip got %0b exp 1", s_clip); end
        if (clip !== 1'b0) begin miscompares++; $display("FAIL sat_shift3_clip got %0b exp 0", clip); end
    endtask

    task automatic test_backpressure_and_reset_mid();
        int ph = 0;
        int first = -1;
        do_reset();
        for (int i = 1; i <= 104; i++) begin
            step(1'b1, ph, 1'b0);
            ph += (i <= 32) ? 3 : (i <= 64) ? 5 : 9;
            vectors++;
            if (out_valid !== (q_a.size() != 0)) begin miscompares++; $display("FAIL bp_valid edge %0d got %0b exp %0b", i, out_valid, q_a.size() != 0); end
        end
        vectors += 3;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid got %0b exp 1", out_valid); end
        if (overflow !== 1'b1) begin miscompares++; $display("FAIL bp_overflow got %0b exp 1", overflow); end
        if (out_data !== 16'sd12) begin miscompares++; $display("FAIL bp_head1 got %0d exp 12", out_data); end
        step(1'b0, ph, 1'b1);
        vectors += 2;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid2 got %0b exp 1", out_valid); end
        if (out_data !== 16'sd20) begin miscompares++; $display("FAIL bp_head2 got %0d exp 20", out_data); end
        step(1'b0, ph, 1'b1);
        vectors += 2;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drained got %0b exp 0", out_valid); end
        if (overflow !== 1'b1) begin miscompares++; $display("FAIL bp_sticky got %0b exp 1", overflow); end
        // partial group with a different slope, then asynchronous reset between edges
        for (int i = 0; i < 10; i++) begin
            step(1'b1, ph, 1'b1);
            ph += 50;
        end
        areset = 1'b1;
        model_reset();
        #2;
        vectors += 3;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL rst_mid_overflow got %0b exp 0", overflow); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid got %0b exp 0", out_valid); end
        if (out_data !== 16'sd0) begin miscompares++; $display("FAIL rst_mid_data got %0d exp 0", out_data); end
        @(posedge clk);
        #1;
        areset = 1'b0;
        for (int i = 1; i <= 37; i++) begin
            step(1'b1, ph, 1'b1);
            ph += 5;
            if (out_valid === 1'b1 && first < 0) begin
                first = i;
                vectors++;
                if (out_data !== 16'sd20) begin miscompares++; $display("FAIL rst_mid_result got %0d exp 20", out_data); end
            end
        end
        vectors++;
        if (first != 36) begin miscompares++; $display("FAIL rst_mid_first got edge %0d exp 36", first); end
    endtask

    task automatic test_random();
        int ph = $urandom_range(0, 4095);
        bit e;
        bit rdy;
        do_reset();
        for (int i = 1; i <= 900; i++) begin
            e   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            if (i > 500 && i < 700) rdy = 1'b0;
            step(e, ph, rdy);
            if (e) ph += ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 600)) - 300;
            vectors += 5;
            if (out_valid !== (q_a.size() != 0)) begin miscompares++; $display("FAIL rnd_valid cyc %0d got %0b exp %0b", i, out_valid, q_a.size() != 0); end
            if (s_valid !== (q_b.size() != 0)) begin miscompares++; $display("FAIL rnd_sat_valid cyc %0d got %0b exp %0b", i, s_valid, q_b.size() != 0); end
            if (overflow !== m_ovf) begin miscompares++; $display("FAIL rnd_overflow cyc %0d got %0b exp %0b", i, overflow, m_ovf); end
            if (clip !== m_clip_a) begin miscompares++; $display("FAIL rnd_clip cyc %0d got %0b exp %0b", i, clip, m_clip_a); end
            if (s_clip !== m_clip_b) begin miscompares++; $display("FAIL rnd_sat_clip cyc %0d got %0b exp %0b", i, s_clip, m_clip_b); end
            if (q_a.size() != 0) begin
                vectors += 2;
                if (out_data !== 16'(q_a[0])) begin miscompares++; $display("FAIL rnd_data cyc %0d got %0d exp %0d", i, out_data, q_a[0]); end
                if (s_data !== 16'(q_b[0])) begin miscompares++; $display("FAIL rnd_sat_data cyc %0d got %0d exp %0d", i, s_data, q_b[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_wrap();
        test_neg_gaps();
        test_saturation();
        test_backpressure_and_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fm_discriminator_decim.md
# fm_discriminator_decim

Downstream FM demodulation stage fed by the phase unwrapper's output, the unwrapped IQ phase. Each clock-enabled cycle it forms the first difference of the phase modulo 2^IN_W, which gives the instantaneous frequency. It then integrates-and-dumps DECIM differences, scales and saturates the sum, and queues the result in a 2-entry output FIFO with a valid/ready handshake. This produces the decimated audio-rate sample stream.

## Interface
- IN_W, 12: phase input width, signed two's complement; full scale = ±π.
- DECIM, 32: decimation ratio, ≥2; ACC_W = IN_W + clog2(DECIM).
- SHIFT, 3: arithmetic right shift applied to the dump sum.
- OUT_W, 16: output sample width, signed.
- clk  in  1  sample clock, rising edge.
- areset  in  1  asynchronous, active-high reset.
- en  in  1  sample enable; phase is consumed only when en=1.
- phase  in  IN_W  unwrapped phase sample.
- out_data  out  OUT_W  frequency sample at the FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head when out_valid & out_ready.
- overflow  out  1  sticky: a result was dropped because the FIFO was full.
- clip  out  1  sticky: a result was saturated.

## Operation
- Stage A, only when en=1:
  - phase_prev <= phase; primed <= 1.
  - If primed was already 1: d <= (phase − phase_prev) mod 2^IN_W, taken as signed; d_vld <= 1.
  - Otherwise d_vld <= 0. The first sample after reset only primes.
  - When en=0: d_vld <= 0, and phase_prev, primed and d hold.
- Stage B, when d_vld=1:
  - If cnt = DECIM−1: sum_r <= acc + sext(d); acc <= 0; cnt <= 0; sum_vld <= 1.
  - Else: acc <= acc + sext(d); cnt <= cnt+1; sum_vld <= 0.
  - When d_vld=0: sum_vld <= 0, and acc and cnt hold.
- Stage C, when sum_vld=1:
  - r = sum_r >>> SHIFT (arithmetic).
  - If r exceeds the OUT_W signed range, clamp it to 2^(OUT_W−1)−1 or −2^(OUT_W−1) and set clip.
  - Push r into the FIFO.
- Output FIFO, 2 entries, in-order:
  - pop = out_valid & out_ready.
  - push & full & pop: the push is accepted.
  - push & full & ~pop: the new result is dropped and overflow is set. FIFO contents are unchanged.
  - push & empty: the entry becomes visible next cycle. There is no combinational bypass.
  - out_data is the head entry, registered. It is undefined when out_valid=0, but the bench checks it as 0 after reset.
- ACC_W is sized so the accumulator never wraps: |sum| ≤ 2^(IN_W−1)·DECIM.

## Timing
- Reset values:
  - phase_prev=0, primed=0, d=0, d_vld=0.
  - acc=0, cnt=0, sum_r=0, sum_vld=0.
  - FIFO empty, out_valid=0, out_data=0, overflow=0, clip=0.
- areset asserted mid-operation:
  - Partial accumulation and FIFO contents are discarded immediately (asynchronous).
  - After deassertion, the first en sample primes again.
- Latency: the phase sample captured at edge k that completes a DECIM group gives d at k+1, sum_r at k+2, and out_valid=1 with its result at k+3.
- Throughput:
  - One result per DECIM enabled samples.
  - With out_ready held at 1, the FIFO never holds more than 1 entry.
  - overflow and clip clear only on areset.
- en gaps stall stages A and B only. Samples are never duplicated, and the gap cycles are not counted.

## Test plan
- Constant ramp at defaults: phase += 5 per cycle, en=1, out_ready=1.
  - First out_valid appears 3 cycles after the 33rd sample edge; out_data = 160>>>3 = 20.
  - Then one result every 32 cycles, each 20.
  - overflow=0, clip=0.
- Wrap-around: ramp +100 crossing 2047→−1949.
  - Every diff is +100; result = 3200>>>3 = 400 with no glitch.
- Negative ramp and en gaps:
  - phase −= 7 per sample, en toggling 1/0: result = −224>>>3 = −28.
  - Results arrive every 64 cycles.
- Saturation with SHIFT=0, OUT_W=16: phase alternating 0, −2048.
  - Each diff is −2048; sum = −65536; out_data = −32768; clip=1.
- Backpressure with out_ready=0 across 3 dump events:
  - out_valid stays 1; third result dropped; overflow=1.
  - Raising out_ready then yields results 1 and 2 in order, then out_valid=0.
- Reset mid-group: assert areset after 10 samples.
  - All outputs return to reset values.
  - Next result needs 1 priming sample plus 32 diffs.
